shift_add_mult: RTL

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/shift_add_mult_if.sv | 27 ++
 rtl/shift_add_mult.sv | 112 +++++++++++
 2 files changed

// File: rtl/shift_add_mult_if.sv
// Operand/result bundle for the shift-and-add multiplier.
//   A, B  : unsigned operands (BITS each), sampled on the accept edge
//   IEA   : level request, start/hold a transaction
//   Y     : registered product (2*BITS)
//   OE    : high while Y holds a valid result
//   BUSY  : high while the product is being computed
// master = requester side, slave = multiplier side.
interface shift_add_mult_if #(
    parameter int unsigned BITS = 32
);
    logic [BITS-1:0]   A;
    logic [BITS-1:0]   B;
    logic              IEA;
    logic [2*BITS-1:0] Y;
    logic              OE;
    logic              BUSY;

    modport master (
        output A, B, IEA,
        input  Y, OE, BUSY
    );

    modport slave (
        input  A, B, IEA,
        output Y, OE, BUSY
    );
endinterface

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per cycle.
//   CLK : sole clock, rising edge
//   RST : synchronous active-high reset
//   bus : shift_add_mult_if.slave (A, B, IEA in; Y, OE, BUSY out)
// A transaction takes exactly BITS calc cycles after the accept edge; the
// result is held with OE=1 until IEA is seen low.
module shift_add_mult #(
    parameter int unsigned BITS = 32
) (
    input  logic           CLK,
    input  logic           RST,
    shift_add_mult_if.slave bus
);
    localparam int unsigned W  = 2 * BITS;
    localparam int unsigned CW = $clog2(BITS + 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StOE
    } state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    mcand, mcand_nxt;
    logic [BITS-1:0] mlt, mlt_nxt;
    logic [W-1:0]    acc, acc_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [W-1:0]    y, y_nxt;
    logic            oe, oe_nxt;
    logic            busy, busy_nxt;
    logic [W-1:0]    acc_sum;

    // Partial-product add for the current multiplier LSB (wraps mod 2^W).
    assign acc_sum = mlt[0] ? (acc + mcand) : acc;

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state;
        mcand_nxt = mcand;
        mlt_nxt   = mlt;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        y_nxt     = y;
        oe_nxt    = oe;
        busy_nxt  = busy;
        case (state)
            StIdle: begin
                oe_nxt   = 1'b0;
                busy_nxt = 1'b0;
                if (bus.IEA) begin
                    mcand_nxt = W'(bus.A);
                    mlt_nxt   = bus.B;
                    acc_nxt   = '0;
                    cnt_nxt   = CW'(BITS);
                    busy_nxt  = 1'b1;
                    state_nxt = StCalc;
                end
            end
            StCalc: begin
                acc_nxt   = acc_sum;
                mcand_nxt = mcand << 1;
                mlt_nxt   = mlt >> 1;
                cnt_nxt   = cnt - CW'(1);
                // Last step: publish the sum including this edge's add.
                if (cnt == CW'(1)) begin
                    y_nxt     = acc_sum;
                    oe_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = StOE;
                end
            end
            StOE: begin
                if (!bus.IEA) begin
                    oe_nxt    = 1'b0;
                    state_nxt = StIdle;
                end
            end
            default: begin
                oe_nxt    = 1'b0;
                busy_nxt  = 1'b0;
                state_nxt = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= StIdle;
            mcand <= '0;
            mlt   <= '0;
            acc   <= '0;
            cnt   <= '0;
            y     <= '0;
            oe    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            mcand <= mcand_nxt;
            mlt   <= mlt_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            y     <= y_nxt;
            oe    <= oe_nxt;
            busy  <= busy_nxt;
        end
    end

    assign bus.Y    = y;
    assign bus.OE   = oe;
    assign bus.BUSY = busy;
endmodule
